// File: rtl/wisc_pkg.sv
// Shared WISC constants: word width, opcode field bounds and the special encodings.
// Used by the IF/ID pipeline register and its sub-modules.
package wisc_pkg;
    localparam int          WORD_W      = 16;
    localparam int          OP_HI       = 15;
    localparam int          OP_LO       = 11;
    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
endpackage

// File: rtl/reg16.sv
// 16-bit register with synchronous active-high reset to a configurable value and a write enable.
// Latency one cycle; contents hold while write_en is low.
module reg16 #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= RST_VAL;
        else if (write_en)
            rdata <= wdata;
    end
endmodule

// File: rtl/sat_counter16.sv
// 16-bit counter with synchronous reset that counts enabled cycles and sticks at 16'hFFFF.
// Latency one cycle; holds when en is low.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= 16'h0000;
        else if (en && count != 16'hFFFF)
            count <= count + 16'h0001;
    end
endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register: one-cycle capture of fetch outputs with stall hold, flush bubble,
// sticky HALT detection and a saturating stall-cycle counter.
module fetch_decode_reg
    import wisc_pkg::*;
#(
    parameter logic [15:0] NOP   = NOP_INSTR,
    parameter logic [4:0]  HALT  = HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_incPC,
    input  logic        if_err,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] id_instr,
    output logic [15:0] id_incPC,
    output logic        id_valid,
    output logic        id_err,
    output logic        id_halt,
    output logic        halt_seen,
    output logic [15:0] stall_count
);
    logic        write_en;
    logic        load_bubble;
    logic        valid_d;
    logic        err_d;
    logic        halt_seen_d;
    logic [15:0] instr_d;
    logic [15:0] pc_d;

    assign write_en = ~stall | flush;

    // Once HALT is in decode nothing younger may follow it until a flush squashes it.
    assign load_bubble = halt_seen | ~if_valid;

    always_comb begin
        instr_d     = if_instr;
        pc_d        = if_incPC;
        valid_d     = 1'b1;
        err_d       = if_err;
        halt_seen_d = halt_seen;
        if (flush) begin
            instr_d     = NOP;
            pc_d        = 16'h0000;
            valid_d     = 1'b0;
            err_d       = 1'b0;
            halt_seen_d = 1'b0;
        end else if (load_bubble) begin
            instr_d = NOP;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (if_instr[OP_HI:OP_LO] == HALT) begin
            halt_seen_d = 1'b1;
        end
    end

    reg16 #(.RST_VAL(NOP)) u_instr_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .wdata    (instr_d),
        .rdata    (id_instr)
    );

    reg16 #(.RST_VAL(16'h0000)) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .wdata    (pc_d),
        .rdata    (id_incPC)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid  <= 1'b0;
            id_err    <= 1'b0;
            halt_seen <= 1'b0;
        end else if (write_en) begin
            id_valid  <= valid_d;
            id_err    <= err_d;
            halt_seen <= halt_seen_d;
        end
    end

    assign id_halt = id_valid & (id_instr[OP_HI:OP_LO] == HALT);

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall & ~flush),
        .count (stall_count)
    );
endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed-vector bench for the IF/ID register: per-cycle table plus saturation and timing sequences.
module tb_fetch_decode_reg;
    import wisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_instr;
    logic [15:0] if_incPC;
    logic        if_err;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic [15:0] id_instr;
    logic [15:0] id_incPC;
    logic        id_valid;
    logic        id_err;
    logic        id_halt;
    logic        halt_seen;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_decode_reg dut (
        .clk         (clk),
        .rst         (rst),
        .if_instr    (if_instr),
        .if_incPC    (if_incPC),
        .if_err      (if_err),
        .if_valid    (if_valid),
        .stall       (stall),
        .flush       (flush),
        .id_instr    (id_instr),
        .id_incPC    (id_incPC),
        .id_valid    (id_valid),
        .id_err      (id_err),
        .id_halt     (id_halt),
        .halt_seen   (halt_seen),
        .stall_count (stall_count)
    );

    typedef struct {
        logic        rst, stall, flush;
        logic [15:0] instr, pc;
        logic        err, valid;
        logic [15:0] e_instr, e_pc;
        logic        chk_pc;
        logic        e_valid, e_err, e_halt, e_hs;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, s, f, input logic [15:0] i, p, input logic e, v,
                       input logic [15:0] ei, ep, input logic cp, ev, ee, eh, ehs,
                       input logic [15:0] ec);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.instr = i; t.pc = p; t.err = e; t.valid = v;
        t.e_instr = ei; t.e_pc = ep; t.chk_pc = cp; t.e_valid = ev; t.e_err = ee;
        t.e_halt = eh; t.e_hs = ehs; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, s, f, input logic [15:0] i, p, input logic e, v);
        rst = r; stall = s; flush = f; if_instr = i; if_incPC = p; if_err = e; if_valid = v;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        //   rst stall flush instr    pc       err valid | instr    pc       chkpc v e halt hs cnt
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0800, 16'h0000, 1, 0, 0, 0, 0, 16'd0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0800, 16'h0000, 1, 0, 0, 0, 0, 16'd0);
        add(0, 0, 0, 16'h4123, 16'h0002, 0, 1, 16'h4123, 16'h0002, 1, 1, 0, 0, 0, 16'd0);
        add(0, 1, 0, 16'h5555, 16'h0004, 0, 1, 16'h4123, 16'h0002, 1, 1, 0, 0, 0, 16'd1);
        add(0, 1, 0, 16'h5555, 16'h0004, 0, 1, 16'h4123, 16'h0002, 1, 1, 0, 0, 0, 16'd2);
        add(0, 1, 0, 16'h5555, 16'h0004, 0, 1, 16'h4123, 16'h0002, 1, 1, 0, 0, 0, 16'd3);
        add(0, 0, 0, 16'h5555, 16'h0004, 0, 1, 16'h5555, 16'h0004, 1, 1, 0, 0, 0, 16'd3);
        add(0, 1, 1, 16'h6000, 16'h0006, 0, 1, 16'h0800, 16'h0000, 1, 0, 0, 0, 0, 16'd3);
        add(0, 0, 0, 16'h0000, 16'h0006, 0, 1, 16'h0000, 16'h0006, 1, 1, 0, 1, 1, 16'd3);
        add(0, 0, 0, 16'h4123, 16'h0008, 0, 1, 16'h0800, 16'h0000, 0, 0, 0, 0, 1, 16'd3);
        add(0, 1, 0, 16'h4123, 16'h0008, 0, 1, 16'h0800, 16'h0000, 0, 0, 0, 0, 1, 16'd4);
        add(0, 0, 1, 16'h4123, 16'h0008, 0, 1, 16'h0800, 16'h0000, 1, 0, 0, 0, 0, 16'd4);
        add(0, 0, 0, 16'h0000, 16'h000A, 0, 1, 16'h0000, 16'h000A, 1, 1, 0, 1, 1, 16'd4);
        add(0, 0, 1, 16'h0000, 16'h000C, 0, 1, 16'h0800, 16'h0000, 1, 0, 0, 0, 0, 16'd4);
        add(0, 0, 0, 16'h4123, 16'h000C, 1, 1, 16'h4123, 16'h000C, 1, 1, 1, 0, 0, 16'd4);
        add(0, 0, 0, 16'h7777, 16'h000E, 1, 0, 16'h0800, 16'h000E, 1, 0, 0, 0, 0, 16'd4);
        add(0, 1, 0, 16'h0000, 16'h0010, 0, 1, 16'h0800, 16'h000E, 1, 0, 0, 0, 0, 16'd5);
        add(1, 1, 0, 16'h4123, 16'h0012, 1, 1, 16'h0800, 16'h0000, 1, 0, 0, 0, 0, 16'd0);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].stall, vecs[k].flush, vecs[k].instr, vecs[k].pc,
                  vecs[k].err, vecs[k].valid);
            @(posedge clk);
            #1;
            check($sformatf("v%0d id_instr", k), id_instr, vecs[k].e_instr);
            if (vecs[k].chk_pc)
                check($sformatf("v%0d id_incPC", k), id_incPC, vecs[k].e_pc);
            check($sformatf("v%0d id_valid", k), {15'h0, id_valid}, {15'h0, vecs[k].e_valid});
            check($sformatf("v%0d id_err", k), {15'h0, id_err}, {15'h0, vecs[k].e_err});
            check($sformatf("v%0d id_halt", k), {15'h0, id_halt}, {15'h0, vecs[k].e_halt});
            check($sformatf("v%0d halt_seen", k), {15'h0, halt_seen}, {15'h0, vecs[k].e_hs});
            check($sformatf("v%0d stall_count", k), stall_count, vecs[k].e_cnt);
        end

        // Outputs must not follow if_* between edges.
        drive(1'b0, 1'b0, 1'b0, 16'h4123, 16'h0020, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("load before comb probe", id_instr, 16'h4123);
        if_instr = 16'h0000;
        if_incPC = 16'hBEEF;
        #2;
        check("no comb path instr", id_instr, 16'h4123);
        check("no comb path pc", id_incPC, 16'h0020);
        check("no comb path halt", {15'h0, id_halt}, 16'h0000);

        // Long stall to drive the counter into saturation.
        drive(1'b0, 1'b1, 1'b0, 16'h5555, 16'h0022, 1'b0, 1'b1);
        repeat (65534) @(posedge clk);
        #1;
        check("count at FFFE", stall_count, 16'hFFFE);
        check("stall holds instr", id_instr, 16'h4123);
        @(posedge clk);
        #1;
        check("count reaches FFFF", stall_count, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        check("count saturated", stall_count, 16'hFFFF);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush keeps count", stall_count, 16'hFFFF);
        check("flush bubble", id_instr, 16'h0800);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset clears saturated count", stall_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_decode_reg.md
Name: fetch_decode_reg

Overview:
IF/ID pipeline register between the fetch stage and the decode stage for the pipelined WISC processor. It captures the fetched instruction, PC+2 and fetch error each cycle, and supports stall (hold), flush (bubble insert) and valid tracking. It detects HALT entering decode and holds a sticky halt flag that drives the fetch stage's halt input. It also keeps a saturating stall-cycle counter for the performance test programs.

Parameters:
NOP_INSTR, 16'h0800, bubble encoding (NOP opcode 00001, remaining bits zero).
HALT_OPCODE, 5'b00000, value of instr[15:11] that identifies HALT.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
if_instr  input  16  instruction from fetch.
if_incPC  input  16  PC+2 from fetch.
if_err  input  1  fetch error (PC adder overflow or PC register error).
if_valid  input  1  fetch output is a real instruction; 0 means bubble.
stall  input  1  hazard unit: hold current contents.
flush  input  1  branch/jump resolution: squash the IF/ID contents.
id_instr  output  16  instruction to decode.
id_incPC  output  16  PC+2 to decode.
id_valid  output  1  id_instr is a real instruction.
id_err  output  1  registered error for the instruction in ID.
id_halt  output  1  combinational: id_valid & (id_instr[15:11] == HALT_OPCODE).
halt_seen  output  1  sticky; feeds the fetch halt input to freeze the PC.
stall_count  output  16  saturating count of cycles with stall=1 (flush=0).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values: id_instr=NOP_INSTR, id_incPC=16'h0000, id_valid=0, id_err=0, halt_seen=0, stall_count=0. id_halt is therefore 0.
- Per-edge priority is rst > flush > stall > load.
- flush=1 (stall ignored):
  - id_instr=NOP_INSTR, id_incPC=0, id_valid=0, id_err=0.
  - halt_seen cleared, because the squashed HALT is younger than the flushing branch.
  - stall_count unchanged.
- stall=1, flush=0:
  - All pipeline fields and halt_seen hold.
  - stall_count increments and saturates at 16'hFFFF.
- Load (neither stall nor flush):
  - If halt_seen=1: load a bubble (NOP, valid=0, err=0). No instruction past HALT enters decode.
  - Else if if_valid=0: load a bubble; id_incPC=if_incPC.
  - Else: id_instr=if_instr, id_incPC=if_incPC, id_valid=1, id_err=if_err.
- halt_seen set:
  - Set on a load edge that captures a valid instruction with instr[15:11]==HALT_OPCODE, so it asserts in the same cycle id_halt first asserts.
  - Stays set through stalls. Cleared only by rst or flush.
  - If a flush and a HALT load coincide, flush wins and halt_seen=0.
- Latency: one cycle from IF inputs to ID outputs. No combinational path from if_* to id_* outputs.
- id_err is not sticky: it follows the captured instruction and is cleared by bubbles.
- Reset mid-stall: rst wins and the counter clears.

Decomposition:
- Shared package wisc_pkg holds constants: NOP_INSTR, HALT_OPCODE, opcode field slice bounds [15:11], and the 16-bit word width.
- Natural sub-module: sat_counter16, a 16-bit saturating counter with synchronous reset and enable, reusable for other performance counters.
- The pipeline fields use the existing reg16 register with writeEnable = ~stall | flush, plus muxed write data.

Test Plan:
- Reset then load: rst=1 for 2 cycles -> id_instr=0x0800, id_valid=0, stall_count=0. Then if_instr=0x4123, if_incPC=0x0002, if_valid=1 -> next cycle id_instr=0x4123, id_incPC=0x0002, id_valid=1.
- Stall hold: load 0x4123, then stall=1 for 3 cycles with if_instr=0x5555 -> id_instr stays 0x4123 and stall_count=3. Deassert stall -> id_instr=0x5555.
- Flush beats stall: stall=1, flush=1, if_instr=0x6000 -> id_instr=0x0800, id_valid=0, stall_count unchanged.
- HALT capture: load 0x0000 valid -> id_halt=1, halt_seen=1. Next load 0x4123 -> id_instr=0x0800, id_valid=0, halt_seen stays 1.
- HALT squash: HALT sits in ID with halt_seen=1, then flush=1 -> halt_seen=0 and id_valid=0. Next load 0x4123 -> id_valid=1.
- Error and saturation: if_err=1 with valid 0x4123 -> id_err=1; a following bubble -> id_err=0. Preset stall_count near 0xFFFF via a long stall (about 65,540 cycles) -> count holds at 0xFFFF.
